// File: rtl/rom_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and constants for the waveform-ROM arbiter
// (rom_rr_arbiter, rr_pick_4).
//   N_REQ        number of requesters (channels a..d)
//   ROM_LATENCY  ROM read latency in cycles (registered output)
//   REQ_ID_W     width of a requester index
//   req_id_t     requester index type
//   gnt_state_e  grant-stage slot state
//   onehot()     requester index -> one-hot requester mask
// ----------------------------------------------------------------------------
package rom_arb_pkg;

    localparam int N_REQ       = 4;
    localparam int ROM_LATENCY = 1;
    localparam int REQ_ID_W    = 2;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef enum logic {
        GNT_IDLE,
        GNT_ISSUE
    } gnt_state_e;

    function automatic logic [N_REQ-1:0] onehot(input req_id_t id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rom_rr_arbiter_rr_pick_4.sv
// ----------------------------------------------------------------------------
// rr_pick_4
// Combinational rotate-priority encoder. Searches the eligible mask starting
// at index ptr and wrapping modulo N_REQ; returns the first set index.
// Ports:
//   elig   in  N_REQ  eligible requester mask
//   ptr    in  2      index with highest priority
//   found  out 1      at least one requester eligible
//   id     out 2      selected requester (ptr when nothing is eligible)
// ----------------------------------------------------------------------------
module rr_pick_4
    import rom_arb_pkg::*;
(
    input  logic [N_REQ-1:0] elig,
    input  req_id_t          ptr,
    output logic             found,
    output req_id_t          id
);

    req_id_t cand;

    always_comb begin
        found = 1'b0;
        id    = ptr;
        cand  = ptr;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // 2-bit addition wraps naturally modulo 4
            cand = ptr + req_id_t'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rom_rr_arbiter
// Shares one registered single-port waveform ROM among 4 sigma-delta channel
// sequencers. Round-robin arbitration drives the ROM enable/address; the
// requester index of each issued read travels down a small pipeline so the
// returned word is tagged with a one-hot valid for the issuing requester.
//
// Timing: request sampled at edge E0 -> o_gnt/o_rom_en/o_rom_addr after E0
// -> ROM registers data at E1 -> o_valid/o_data registered at E2.
// A requester granted in the current cycle is masked for one edge, so a held
// request gets at most one grant every 2 cycles.
//
// Build option:
//   ROM_ARB_FIXED_PRIO_EN  fixed priority 0 > 1 > 2 > 3 (no rotating pointer)
//
// Ports:
//   i_clk       in  1               system clock
//   i_rst       in  1               synchronous active-high reset
//   i_en        in  1               arbiter enable; low blocks new grants
//   i_req       in  4               level request per requester
//   i_addr      in  4*ADDR_WIDTH    packed addresses, requester k at
//                                   [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_gnt       out 4               one-hot grant pulse
//   o_rom_en    out 1               ROM read enable
//   o_rom_addr  out ADDR_WIDTH      ROM address (held when idle)
//   i_rom_data  in  DATA_WIDTH      ROM data, valid the cycle after o_rom_en
//   o_valid     out 4               one-hot data-valid pulse
//   o_data      out DATA_WIDTH      returned word (held when o_valid=0)
// ----------------------------------------------------------------------------
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_addr,
    output logic [N_REQ-1:0]            o_gnt,
    output logic                        o_rom_en,
    output logic [ADDR_WIDTH-1:0]       o_rom_addr,
    input  logic [DATA_WIDTH-1:0]       i_rom_data,
    output logic [N_REQ-1:0]            o_valid,
    output logic [DATA_WIDTH-1:0]       o_data
);

    localparam int LAST = ROM_LATENCY - 1;

    logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
    logic [N_REQ-1:0]      elig;
    logic                  pick_found;
    req_id_t               pick_id;
    logic                  grant_go;

    gnt_state_e            gnt_state;
    gnt_state_e            gnt_state_d;
    req_id_t               slot0_id;
    logic [N_REQ-1:0]      gnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;

    // Return stage: one requester ID + valid per ROM latency cycle
    logic                  ret_vld [ROM_LATENCY];
    req_id_t               ret_id  [ROM_LATENCY];

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            addr_arr[k] = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // A requester holding a grant right now is not eligible this edge
    assign elig = i_req & ~o_gnt;

`ifdef ROM_ARB_FIXED_PRIO_EN
    rr_pick_4 u_pick (
        .elig  (elig),
        .ptr   ('0),
        .found (pick_found),
        .id    (pick_id)
    );
`else
    req_id_t ptr;
    req_id_t ptr_d;

    rr_pick_4 u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .found (pick_found),
        .id    (pick_id)
    );

    always_comb begin
        ptr_d = ptr;
        if (grant_go) begin
            ptr_d = pick_id + req_id_t'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_d;
        end
    end
`endif

    assign grant_go = i_en && pick_found;

    // Grant stage: next-state and next-output logic
    always_comb begin
        gnt_state_d = GNT_IDLE;
        gnt_d       = '0;
        addr_d      = o_rom_addr;
        if (grant_go) begin
            gnt_state_d = GNT_ISSUE;
            gnt_d       = onehot(pick_id);
            addr_d      = addr_arr[pick_id];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_state <= GNT_IDLE;
        end else begin
            gnt_state <= gnt_state_d;
        end
    end

    assign o_rom_en = (gnt_state == GNT_ISSUE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_gnt      <= '0;
            o_rom_addr <= '0;
            slot0_id   <= '0;
            o_valid    <= '0;
            o_data     <= '0;
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                ret_vld[i] <= 1'b0;
                ret_id[i]  <= '0;
            end
        end else begin
            o_gnt      <= gnt_d;
            o_rom_addr <= addr_d;
            if (grant_go) begin
                slot0_id <= pick_id;
            end

            ret_vld[0] <= (gnt_state == GNT_ISSUE);
            ret_id[0]  <= slot0_id;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                ret_vld[i] <= ret_vld[i-1];
                ret_id[i]  <= ret_id[i-1];
            end

            if (ret_vld[LAST]) begin
                o_valid <= onehot(ret_id[LAST]);
                o_data  <= i_rom_data;
            end else begin
                o_valid <= '0;
            end
        end
    end

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares one registered, single-read-port waveform ROM among 4 requesters (channels a–d) of the iCE40 sigma-delta modulator.
- Arbitrates with a round-robin scheme and drives the ROM enable and address.
- Tracks in-flight reads in a small pipeline and returns each ROM word to the requester that issued the read, with a per-requester valid pulse.
- Sits between the per-channel waveform sequencers and a single-port ROM instance.

Parameters:
- ADDR_WIDTH, 9, ROM address width.
- DATA_WIDTH, 8, ROM data width.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_en  in  1  arbiter enable; low blocks new grants.
- i_req  in  4  level request per requester; bit k = channel k (0 = a … 3 = d).
- i_addr  in  4*ADDR_WIDTH  packed addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]. Must be held stable while i_req[k]=1.
- o_gnt  out  4  one-hot grant pulse, registered.
- o_rom_en  out  1  ROM read enable, registered.
- o_rom_addr  out  ADDR_WIDTH  ROM address, registered.
- i_rom_data  in  DATA_WIDTH  ROM output; valid in the cycle after o_rom_en=1.
- o_valid  out  4  one-hot data-valid pulse, registered.
- o_data  out  DATA_WIDTH  returned ROM word, registered; shared by all requesters.

Behaviour:
- Reset (i_rst=1 at an edge):
  - o_gnt=0, o_rom_en=0, o_rom_addr=0, o_valid=0, o_data=0.
  - Round-robin pointer set so requester 0 has highest priority.
  - In-flight pipeline cleared; reads in flight are discarded, so no o_valid follows.
- Eligibility: requester k is eligible at an edge iff i_req[k]=1 AND o_gnt[k]=0 (a request being granted this cycle is masked).
  - A continuously held request therefore receives at most one grant every 2 cycles.
- Arbitration, at each edge with i_en=1 and at least one eligible requester:
  - Pick the first eligible requester, searching from ptr upward modulo 4.
  - Register o_gnt=onehot(k), o_rom_en=1, o_rom_addr=addr[k].
  - Set ptr=(k+1) mod 4.
  - Otherwise register o_gnt=0, o_rom_en=0, and hold o_rom_addr.
- Pipeline, 3 stages:
  - Edge E0: request sampled.
  - Cycle after E0: o_gnt, o_rom_en and o_rom_addr high/valid.
  - Edge E1: ROM registers the data.
  - Edge E2: arbiter registers o_data=i_rom_data and o_valid=onehot(k).
  - Latency: 3 edges from the request-sampling edge to o_valid.
  - Throughput: 1 read per cycle across different requesters.
- FSM per pipeline slot:
  - Grant stage states IDLE/ISSUE.
  - Return stage is a 2-bit requester-ID register plus a valid flag, one per stage (2 slots).
- o_data holds its last value when o_valid=0.
- i_en falling: no new grants from that edge; up to 2 in-flight reads still complete with o_valid. i_en rising: arbitration resumes with the pointer preserved.
- Simultaneous requests on all 4 channels with ptr=0: grants go 0,1,2,3,0,… one per cycle.
- Address changed while a request is pending: undefined (protocol violation); the bench asserts against it.

Optional Feature:
- Macro ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority 0>1>2>3; the pointer is removed and lower-index requesters can starve higher ones.
- Undefined (default): round robin as above.
- Latency, eligibility masking and reset behaviour are identical in both builds.

Decomposition:
- Package rom_arb_pkg:
  - N_REQ=4.
  - ROM_LATENCY=1.
  - REQ_ID_W=2.
  - typedef req_id_t (2-bit).
  - Function onehot(req_id_t).
- Sub-module rr_pick_4: combinational rotate-priority-encode of a 4-bit eligible mask given ptr; outputs found flag and req_id_t.
  - Under ROM_ARB_FIXED_PRIO_EN, ptr is tied to 0.

Test Plan:
- Reset then single request: i_req=4'b0100, addr[2]=9'h1A5, ROM word 0x5C at 0x1A5.
  - o_gnt=4'b0100 and o_rom_addr=0x1A5 1 cycle after sampling.
  - o_valid=4'b0100 and o_data=0x5C 3 cycles after sampling.
- All four requests held from ptr=0:
  - Grant sequence 0,1,2,3 on consecutive cycles.
  - o_valid sequence identical, 2 cycles later, each with the correct word.
- Held single request i_req=4'b0001: grants on alternate cycles only (0001, 0000, 0001 …).
- i_en dropped the cycle after 2 grants issue:
  - Both o_valid pulses still appear.
  - No further o_gnt until i_en=1.
  - The next grant follows the preserved ptr.
- i_rst asserted 1 cycle after a grant: o_valid stays 0, all outputs are 0 the next cycle, and ptr is back to 0.
- With ROM_ARB_FIXED_PRIO_EN and i_req=4'b1001 held: requester 0 is granted on every eligible cycle; requester 3 is granted only on the alternate cycles when requester 0 is masked.
